// File: rtl/control_sequencer_if.sv
// Control bus between the instruction sequencer and the datapath/memory side.
// master = sequencer (drives control outputs), slave = datapath (drives status).
// Handshake: inst_valid is sampled only while the sequencer idles waiting for an
// instruction; inst_type/funct must stay stable from that cycle until the next
// inst_fetch pulse. data_req stays high until a cycle with data_ack=1, which
// completes the access in that same cycle.
interface control_sequencer_if #(
  parameter int FUNCT_WIDTH  = 4,
  parameter int ALU_OP_WIDTH = 3
);
  logic [2:0]              inst_type;
  logic                    inst_valid;
  logic [FUNCT_WIDTH-1:0]  funct;
  logic                    alu_comp;
  logic                    data_ack;
  logic                    inst_fetch;
  logic                    data_req;
  logic                    data_we;
  logic                    rd_en;
  logic                    rs1_en;
  logic                    rs2_en;
  logic [1:0]              rd_din_sel;
  logic [1:0]              pc_next_sel;
  logic                    alu_din1_sel;
  logic                    alu_din2_sel;
  logic [ALU_OP_WIDTH-1:0] alu_op;
  logic                    busy;
  logic                    err;

  modport master (
    input  inst_type, inst_valid, funct, alu_comp, data_ack,
    output inst_fetch, data_req, data_we, rd_en, rs1_en, rs2_en, rd_din_sel,
           pc_next_sel, alu_din1_sel, alu_din2_sel, alu_op, busy, err
  );

  modport slave (
    output inst_type, inst_valid, funct, alu_comp, data_ack,
    input  inst_fetch, data_req, data_we, rd_en, rs1_en, rs2_en, rd_din_sel,
           pc_next_sel, alu_din1_sel, alu_din2_sel, alu_op, busy, err
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle instruction control sequencer. Only the state and the memory
// timeout counter are registered; every control output is decoded from the
// current state and the live instruction/status inputs.
module control_sequencer #(
  parameter int FUNCT_WIDTH  = 4,
  parameter int ALU_OP_WIDTH = 3,
  parameter int MEM_TIMEOUT  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  control_sequencer_if.master   bus,
  output logic [2:0]            dbg_state
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_IDLE, S_DECODE, S_EXEC, S_MEM, S_TRAP
  } state_t;

  localparam logic [2:0] T_IMM = 3'd0, T_INT_IMM = 3'd1, T_INT_REG = 3'd2,
                         T_BRANCH = 3'd3, T_LOAD = 3'd4, T_STORE = 3'd5,
                         T_JAL = 3'd6, T_ILLEGAL = 3'd7;

  localparam logic [1:0] RD_ALU = 2'd0, RD_IMM = 2'd1, RD_MEM = 2'd2, RD_PC4 = 2'd3;
  localparam logic [1:0] PC_STALL = 2'd0, PC_INCR = 2'd1, PC_BRANCH = 2'd2, PC_JAL = 2'd3;

  localparam logic [ALU_OP_WIDTH-1:0] OP_NOP = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] OP_ADD = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SUB = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] OP_EQ  = ALU_OP_WIDTH'(3);
  localparam logic [ALU_OP_WIDTH-1:0] OP_NE  = ALU_OP_WIDTH'(4);

  state_t        state;
  logic [CW-1:0] cnt;

  logic is_mem_type;
  assign is_mem_type = (bus.inst_type == T_LOAD) || (bus.inst_type == T_STORE);
  assign dbg_state   = state;

  // State transitions and the saturating MEM wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_RESET;
      cnt   <= '0;
    end else begin
      case (state)
        S_RESET:  state <= S_FETCH;
        S_FETCH:  state <= S_IDLE;
        S_IDLE:   if (bus.inst_valid) state <= S_DECODE;
        S_DECODE: begin
          if (bus.inst_type == T_IMM)          state <= S_FETCH;
          else if (bus.inst_type == T_ILLEGAL) state <= S_TRAP;
          else                                 state <= S_EXEC;
        end
        S_EXEC: begin
          if (is_mem_type) begin
            state <= S_MEM;
            cnt   <= '0;
          end else begin
            state <= S_FETCH;
          end
        end
        S_MEM: begin
          // An ack on the final allowed cycle still completes normally.
          if (bus.data_ack) begin
            state <= S_FETCH;
          end else begin
            if (cnt == CW'(MEM_TIMEOUT - 1)) state <= S_TRAP;
            if (cnt != {CW{1'b1}}) cnt <= cnt + 1'b1;
          end
        end
        S_TRAP:   state <= S_TRAP;
        default:  state <= S_RESET;
      endcase
    end
  end

  // Control output decode from state and live inputs; RESET, IDLE and TRAP
  // leave everything at default (TRAP additionally raises err).
  always_comb begin
    bus.inst_fetch   = 1'b0;
    bus.data_req     = 1'b0;
    bus.data_we      = 1'b0;
    bus.rd_en        = 1'b0;
    bus.rs1_en       = 1'b0;
    bus.rs2_en       = 1'b0;
    bus.rd_din_sel   = RD_ALU;
    bus.pc_next_sel  = PC_STALL;
    bus.alu_din1_sel = 1'b0;
    bus.alu_din2_sel = 1'b0;
    bus.alu_op       = OP_NOP;
    bus.busy         = 1'b0;
    bus.err          = 1'b0;
    case (state)
      S_FETCH: begin
        bus.busy       = 1'b1;
        bus.inst_fetch = 1'b1;
      end
      S_DECODE: begin
        bus.busy = 1'b1;
        case (bus.inst_type)
          T_IMM: begin
            bus.rd_en       = 1'b1;
            bus.rd_din_sel  = RD_IMM;
            bus.pc_next_sel = PC_INCR;
          end
          T_INT_IMM, T_LOAD: bus.rs1_en = 1'b1;
          T_INT_REG, T_BRANCH, T_STORE: begin
            bus.rs1_en = 1'b1;
            bus.rs2_en = 1'b1;
          end
          default: ;
        endcase
      end
      S_EXEC: begin
        bus.busy = 1'b1;
        case (bus.inst_type)
          T_INT_IMM, T_INT_REG: begin
            bus.rd_en        = 1'b1;
            bus.rd_din_sel   = RD_ALU;
            bus.alu_din2_sel = (bus.inst_type == T_INT_IMM);
            bus.pc_next_sel  = PC_INCR;
            if (bus.funct == FUNCT_WIDTH'(0))      bus.alu_op = OP_ADD;
            else if (bus.funct == FUNCT_WIDTH'(1)) bus.alu_op = OP_SUB;
          end
          T_BRANCH: begin
            if (bus.funct == FUNCT_WIDTH'(2))      bus.alu_op = OP_EQ;
            else if (bus.funct == FUNCT_WIDTH'(3)) bus.alu_op = OP_NE;
            bus.pc_next_sel = bus.alu_comp ? PC_BRANCH : PC_INCR;
          end
          T_JAL: begin
            bus.rd_en       = 1'b1;
            bus.rd_din_sel  = RD_PC4;
            bus.pc_next_sel = PC_JAL;
          end
          T_LOAD, T_STORE: begin
            bus.alu_op       = OP_ADD;
            bus.alu_din2_sel = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        bus.busy         = 1'b1;
        bus.data_req     = 1'b1;
        bus.data_we      = (bus.inst_type == T_STORE);
        bus.alu_op       = OP_ADD;
        bus.alu_din2_sel = 1'b1;
        if (bus.data_ack) begin
          bus.pc_next_sel = PC_INCR;
          if (bus.inst_type == T_LOAD) begin
            bus.rd_en      = 1'b1;
            bus.rd_din_sel = RD_MEM;
          end
        end
      end
      S_TRAP:  bus.err = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: an instruction-level model expands each
// instruction into its expected per-cycle control outputs; a negedge compare
// process checks the DUT against that expectation every cycle.
module tb_control_sequencer;
  localparam int MEM_TIMEOUT = 4;

  typedef struct packed {
    logic       inst_fetch;
    logic       data_req;
    logic       data_we;
    logic       rd_en;
    logic       rs1_en;
    logic       rs2_en;
    logic [1:0] rd_din_sel;
    logic [1:0] pc_next_sel;
    logic       din1;
    logic       din2;
    logic [2:0] alu_op;
    logic       busy;
    logic       err;
  } outs_t;
  localparam int OW = $bits(outs_t);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  control_sequencer_if #(.FUNCT_WIDTH(4), .ALU_OP_WIDTH(3)) bus ();
  logic [2:0] dbg_state;

  control_sequencer #(.FUNCT_WIDTH(4), .ALU_OP_WIDTH(3), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [OW-1:0] exp_q[$];

  function automatic outs_t blank(input logic busy);
    outs_t e;
    e = '0;
    e.busy = busy;
    return e;
  endfunction

  function automatic outs_t sample();
    outs_t g;
    g.inst_fetch  = bus.inst_fetch;
    g.data_req    = bus.data_req;
    g.data_we     = bus.data_we;
    g.rd_en       = bus.rd_en;
    g.rs1_en      = bus.rs1_en;
    g.rs2_en      = bus.rs2_en;
    g.rd_din_sel  = bus.rd_din_sel;
    g.pc_next_sel = bus.pc_next_sel;
    g.din1        = bus.alu_din1_sel;
    g.din2        = bus.alu_din2_sel;
    g.alu_op      = bus.alu_op;
    g.busy        = bus.busy;
    g.err         = bus.err;
    return g;
  endfunction

  // scoreboard: one expected vector per clock cycle, checked mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [OW-1:0] e;
      logic [OW-1:0] g;
      e = exp_q.pop_front();
      g = sample();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL outs t=%0t got=%b exp=%b (fetch,req,we,rd,rs1,rs2,rdsel,pcsel,d1,d2,op,busy,err)",
                 $time, g, e);
      end
    end
  end

  // hand-computed literal checks
  task automatic pin(input string name, input logic [2:0] got, input logic [2:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  // driver: inputs already set; queue the expectation for this cycle and advance
  task automatic cyc(input outs_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.inst_type  = 3'd0;
    bus.inst_valid = 1'b0;
    bus.funct      = 4'd0;
    bus.alu_comp   = 1'b0;
    bus.data_ack   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    pin("rst_fetch", {2'b0, bus.inst_fetch}, 3'd0);
    pin("rst_busy",  {2'b0, bus.busy}, 3'd0);
    pin("rst_err",   {2'b0, bus.err}, 3'd0);
    pin("rst_pcsel", {1'b0, bus.pc_next_sel}, 3'd0);
    rst = 1'b1;
    cyc(blank(1'b0));  // still in RESET for this cycle: all defaults
  endtask

  // Model of one instruction, starting in the fetch cycle. ack_at: MEM cycle on
  // which data_ack is given (0 = never). stop_mem: leave after that many MEM
  // cycles without completing (0 = run to the end).
  task automatic run_inst(input logic [2:0] t, input logic [3:0] f, input logic comp,
                          input int ack_at, input int idle_wait, input int stop_mem,
                          output logic trapped);
    outs_t e;
    trapped = 1'b0;
    clear_inputs();
    e = blank(1'b1);
    e.inst_fetch = 1'b1;
    cyc(e);
    for (int i = 0; i < idle_wait; i++) cyc(blank(1'b0));
    bus.inst_valid = 1'b1;
    bus.inst_type  = t;
    bus.funct      = f;
    bus.alu_comp   = comp;
    cyc(blank(1'b0));
    bus.inst_valid = 1'b0;
    // decode cycle
    e = blank(1'b1);
    case (t)
      3'd0: begin e.rd_en = 1'b1; e.rd_din_sel = 2'd1; e.pc_next_sel = 2'd1; end
      3'd1, 3'd4: e.rs1_en = 1'b1;
      3'd2, 3'd3, 3'd5: begin e.rs1_en = 1'b1; e.rs2_en = 1'b1; end
      default: ;
    endcase
    cyc(e);
    if (t == 3'd0) return;
    if (t == 3'd7) begin trapped = 1'b1; return; end
    // execute cycle
    e = blank(1'b1);
    case (t)
      3'd1, 3'd2: begin
        e.rd_en = 1'b1;
        e.din2 = (t == 3'd1);
        e.pc_next_sel = 2'd1;
        e.alu_op = (f == 4'd0) ? 3'd1 : (f == 4'd1) ? 3'd2 : 3'd0;
      end
      3'd3: begin
        e.alu_op = (f == 4'd2) ? 3'd3 : (f == 4'd3) ? 3'd4 : 3'd0;
        e.pc_next_sel = comp ? 2'd2 : 2'd1;
      end
      3'd6: begin e.rd_en = 1'b1; e.rd_din_sel = 2'd3; e.pc_next_sel = 2'd3; end
      default: begin e.alu_op = 3'd1; e.din2 = 1'b1; end
    endcase
    cyc(e);
    if (t != 3'd4 && t != 3'd5) return;
    // memory wait cycles
    for (int k = 1; k <= MEM_TIMEOUT; k++) begin
      if (stop_mem != 0 && k > stop_mem) return;
      bus.data_ack = (k == ack_at);
      e = blank(1'b1);
      e.data_req = 1'b1;
      e.data_we  = (t == 3'd5);
      e.alu_op   = 3'd1;
      e.din2     = 1'b1;
      if (k == ack_at) begin
        e.pc_next_sel = 2'd1;
        if (t == 3'd4) begin e.rd_en = 1'b1; e.rd_din_sel = 2'd2; end
        cyc(e);
        bus.data_ack = 1'b0;
        return;
      end
      cyc(e);
    end
    trapped = 1'b1;
  endtask

  // trapped: only err stays up, and new instructions do not wake it
  task automatic trap_cycles(input int n);
    outs_t e;
    e = blank(1'b0);
    e.err = 1'b1;
    bus.inst_valid = 1'b1;
    bus.inst_type  = 3'd0;
    bus.data_ack   = 1'b1;
    for (int i = 0; i < n; i++) cyc(e);
    clear_inputs();
  endtask

  logic trapped;

  initial begin
    clear_inputs();
    do_reset();
    run_inst(3'd0, 4'd0, 1'b0, 0, 0, 0, trapped);    // IMM
    run_inst(3'd2, 4'd1, 1'b0, 0, 2, 0, trapped);    // INT_REG SUB
    run_inst(3'd1, 4'd0, 1'b0, 0, 1, 0, trapped);    // INT_IMM ADD
    run_inst(3'd1, 4'd5, 1'b0, 0, 0, 0, trapped);    // INT_IMM unsupported funct
    run_inst(3'd3, 4'd2, 1'b1, 0, 0, 0, trapped);    // BRANCH EQ taken
    run_inst(3'd3, 4'd2, 1'b0, 0, 0, 0, trapped);    // BRANCH EQ not taken
    run_inst(3'd3, 4'd3, 1'b1, 0, 1, 0, trapped);    // BRANCH NE taken
    run_inst(3'd6, 4'd0, 1'b0, 0, 0, 0, trapped);    // JAL
    run_inst(3'd4, 4'd0, 1'b0, 4, 0, 0, trapped);    // LOAD, ack on last allowed cycle
    pin("load_last_ack_no_trap", {2'b0, trapped}, 3'd0);
    run_inst(3'd4, 4'd0, 1'b0, 1, 0, 0, trapped);    // LOAD, immediate ack
    run_inst(3'd5, 4'd0, 1'b0, 2, 0, 0, trapped);    // STORE, ack on 2nd cycle
    run_inst(3'd5, 4'd0, 1'b0, 0, 0, 0, trapped);    // STORE, timeout
    pin("store_timeout", {2'b0, trapped}, 3'd1);
    trap_cycles(3);
    pin("trap_err_sticky", {2'b0, bus.err}, 3'd1);
    do_reset();
    run_inst(3'd7, 4'd0, 1'b0, 0, 0, 0, trapped);    // illegal type
    trap_cycles(2);
    pin("illegal_err", {2'b0, bus.err}, 3'd1);
    do_reset();
    run_inst(3'd4, 4'd0, 1'b0, 0, 0, 2, trapped);    // LOAD, reset lands mid-MEM
    #2;
    pin("mid_mem_req", {2'b0, bus.data_req}, 3'd1);
    rst = 1'b0;
    #1;
    pin("async_req_drop", {2'b0, bus.data_req}, 3'd0);
    pin("async_busy",     {2'b0, bus.busy}, 3'd0);
    pin("async_err",      {2'b0, bus.err}, 3'd0);
    do_reset();
    run_inst(3'd0, 4'd0, 1'b0, 0, 0, 0, trapped);    // IMM after reset
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
